// File: rtl/video_pkg.sv
// Shared video types and default screen geometry for the pixel stream blocks.
package video_pkg;

  localparam int unsigned PIX_DATA_W        = 32;
  localparam int unsigned PIX_RGB_W         = 24;
  localparam int unsigned DEF_SCREEN_WIDTH  = 640;
  localparam int unsigned DEF_SCREEN_HEIGHT = 480;

  // Coordinate-tagged pixel carried through the sink buffer.
  typedef struct packed {
    logic [PIX_RGB_W-1:0]  colour;
    logic [PIX_DATA_W-1:0] x;
    logic [PIX_DATA_W-1:0] y;
  } pixel_t;

  typedef enum logic {
    HUNT   = 1'b0,
    ACTIVE = 1'b1
  } sink_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Two-entry synchronous FIFO of pixel_t.
// Ports: clk/reset (async active-high), push/wr_data write side,
// pop/rd_data read side (rd_data is the head entry), full/empty flags
// decoded from the registered occupancy count.
module pixel_fifo
  import video_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  pixel_t wr_data,
  input  logic   pop,
  output pixel_t rd_data,
  output logic   full,
  output logic   empty
);

  pixel_t     mem_q [2];
  pixel_t     mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       push_ok, pop_ok;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign rd_data = mem_q[rd_ptr_q];

  // Guard against overflow/underflow even if the caller misbehaves.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Next-state pointers, storage and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pixel_stream_sink.sv
// Pixel stream sink: rebuilds x/y coordinates from first/last_x/last_y
// framing, checks framing against the screen geometry and buffers tagged
// pixels for a valid/ready consumer.
// Ports: clk, reset (async active-high); upstream colour_i/first/last_x/
// last_y/valid with ready; downstream xpixel/ypixel/colour_o/pix_valid with
// pix_ready; status frame_done (pulse), frame_count, err_geom (sticky).
module pixel_stream_sink
  import video_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = PIX_DATA_W,
  parameter int unsigned RBG_SIZE      = PIX_RGB_W,
  parameter int unsigned SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
  parameter int unsigned SCREEN_HEIGHT = DEF_SCREEN_HEIGHT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [RBG_SIZE-1:0]   colour_i,
  input  logic                  first,
  input  logic                  last_x,
  input  logic                  last_y,
  input  logic                  valid,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] xpixel,
  output logic [DATA_WIDTH-1:0] ypixel,
  output logic [RBG_SIZE-1:0]   colour_o,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  frame_done,
  output logic [15:0]           frame_count,
  output logic                  err_geom
);

  localparam logic [DATA_WIDTH-1:0] X_LAST = DATA_WIDTH'(SCREEN_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] Y_LAST = DATA_WIDTH'(SCREEN_HEIGHT - 1);

  sink_state_t           state_q, state_d;
  logic [DATA_WIDTH-1:0] x_q, x_d;
  logic [DATA_WIDTH-1:0] y_q, y_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;
  logic [15:0]           fcount_q, fcount_d;
  logic                  rdy_en_q;

  logic                  accept;
  logic                  push;
  logic [DATA_WIDTH-1:0] push_x, push_y;
  logic                  exp_last_x, exp_last_y;
  logic                  fifo_full, fifo_empty;
  pixel_t                wr_pix, head;

  // Holds ready low through reset and releases it on the first clock after.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdy_en_q <= 1'b0;
    else       rdy_en_q <= 1'b1;
  end

  assign ready      = rdy_en_q && !fifo_full;
  assign pix_valid  = !fifo_empty;
  assign accept     = valid && ready;
  assign exp_last_x = (x_q == X_LAST);
  assign exp_last_y = exp_last_x && (y_q == Y_LAST);

  // Deframer: next state, coordinates and status.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    err_d    = err_q;
    done_d   = 1'b0;
    fcount_d = fcount_q;
    push     = 1'b0;
    push_x   = x_q;
    push_y   = y_q;
    if (accept) begin
      if (first) begin
        // A first beat always restarts the frame; in ACTIVE it is a resync.
        if (state_q == ACTIVE) err_d = 1'b1;
        push    = 1'b1;
        push_x  = '0;
        push_y  = '0;
        x_d     = DATA_WIDTH'(1);
        y_d     = '0;
        state_d = ACTIVE;
      end else if (state_q == ACTIVE) begin
        if ((last_x != exp_last_x) || (last_y != exp_last_y)) begin
          err_d   = 1'b1;
          state_d = HUNT;
        end else begin
          push = 1'b1;
          if (exp_last_y) begin
            done_d   = 1'b1;
            fcount_d = fcount_q + 16'd1;
            x_d      = '0;
            y_d      = '0;
            state_d  = HUNT;
          end else if (exp_last_x) begin
            x_d = '0;
            y_d = y_q + DATA_WIDTH'(1);
          end else begin
            x_d = x_q + DATA_WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= HUNT;
      x_q      <= '0;
      y_q      <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      fcount_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      err_q    <= err_d;
      done_q   <= done_d;
      fcount_q <= fcount_d;
    end
  end

  always_comb begin
    wr_pix        = '0;
    wr_pix.colour = PIX_RGB_W'(colour_i);
    wr_pix.x      = PIX_DATA_W'(push_x);
    wr_pix.y      = PIX_DATA_W'(push_y);
  end

  pixel_fifo u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (wr_pix),
    .pop     (pix_ready),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign xpixel      = DATA_WIDTH'(head.x);
  assign ypixel      = DATA_WIDTH'(head.y);
  assign colour_o    = RBG_SIZE'(head.colour);
  assign frame_done  = done_q;
  assign frame_count = fcount_q;
  assign err_geom    = err_q;

endmodule

// File: tb/tb_pixel_stream_sink.sv
// Self-checking bench for pixel_stream_sink on a 4x2 screen.
module tb_pixel_stream_sink;

  localparam int W = 4;
  localparam int H = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] colour_i = '0;
  logic        first = 1'b0, last_x = 1'b0, last_y = 1'b0, valid = 1'b0;
  logic        ready;
  logic [31:0] xpixel, ypixel;
  logic [23:0] colour_o;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        err_geom;

  pixel_stream_sink #(
    .DATA_WIDTH(32), .RBG_SIZE(24), .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H)
  ) dut (
    .clk(clk), .reset(reset), .colour_i(colour_i), .first(first),
    .last_x(last_x), .last_y(last_y), .valid(valid), .ready(ready),
    .xpixel(xpixel), .ypixel(ypixel), .colour_o(colour_o),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .frame_done(frame_done),
    .frame_count(frame_count), .err_geom(err_geom)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] c;
    int          x;
    int          y;
  } exp_t;

  exp_t exp_q[$];
  exp_t ce;
  int   vectors = 0;
  int   miscompares = 0;
  bit   m_hunt = 1'b1;
  int   m_pos = 0;
  bit   m_err = 1'b0;
  int   m_frames = 0;
  bit   rand_ready = 1'b0;

  // Reference model: frame position kept as a linear pixel index.
  function automatic void model_accept(input logic [23:0] c, input bit f,
                                       input bit lx, input bit ly,
                                       output bit done);
    exp_t e;
    int x, y;
    done = 1'b0;
    if (f) begin
      if (!m_hunt) m_err = 1'b1;
      e.c = c; e.x = 0; e.y = 0;
      exp_q.push_back(e);
      m_pos  = 1;
      m_hunt = 1'b0;
    end else if (!m_hunt) begin
      x = m_pos % W;
      y = m_pos / W;
      if ((lx != (x == W - 1)) || (ly != (m_pos == W * H - 1))) begin
        m_err  = 1'b1;
        m_hunt = 1'b1;
      end else begin
        e.c = c; e.x = x; e.y = y;
        exp_q.push_back(e);
        if (m_pos == W * H - 1) begin
          done = 1'b1;
          m_frames++;
          m_hunt = 1'b1;
        end else begin
          m_pos++;
        end
      end
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_hunt = 1'b1; m_pos = 0; m_err = 1'b0; m_frames = 0;
  endfunction

  task automatic drive_beat(input logic [23:0] c, input bit f, input bit lx, input bit ly);
    bit acc = 1'b0;
    bit exp_done = 1'b0;
    int waitc = 0;
    colour_i = c; first = f; last_x = lx; last_y = ly; valid = 1'b1;
    while (!acc && waitc <= 60) begin
      if (rand_ready) pix_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (ready) begin
        acc = 1'b1;
        model_accept(c, f, lx, ly, exp_done);
      end
      @(posedge clk); #1;
      if (!acc) waitc++;
    end
    valid = 1'b0;
    vectors++;
    if (!acc) begin
      miscompares++;
      $display("FAIL accept_timeout ready stuck at %0b, required 1", ready);
    end else begin
      if (frame_done !== exp_done) begin
        miscompares++;
        $display("FAIL frame_done got %0b exp %0b", frame_done, exp_done);
      end
      if (frame_count !== 16'(m_frames)) begin
        miscompares++;
        $display("FAIL frame_count got %0d exp %0d", frame_count, m_frames);
      end
      if (err_geom !== m_err) begin
        miscompares++;
        $display("FAIL err_geom got %0b exp %0b", err_geom, m_err);
      end
    end
  endtask

  task automatic send_pixels(input int from_p);
    for (int p = from_p; p < W * H; p++)
      drive_beat(24'($urandom), p == 0, (p % W) == W - 1, p == W * H - 1);
  endtask

  task automatic drain();
    int n = 0;
    pix_ready = 1'b1;
    while ((pix_valid || exp_q.size() != 0) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (exp_q.size() != 0 || pix_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drain pending=%0d pix_valid=%0b, required 0/0", exp_q.size(), pix_valid);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({ready, pix_valid, frame_done, err_geom} !== 4'b0000 || xpixel !== 32'd0 ||
        ypixel !== 32'd0 || colour_o !== 24'd0 || frame_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_values rdy=%0b pv=%0b fd=%0b err=%0b x=%0d y=%0d c=%h fc=%0d, required all 0",
               ready, pix_valid, frame_done, err_geom, xpixel, ypixel, colour_o, frame_count);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (ready !== 1'b1 || pix_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release ready=%0b pix_valid=%0b, required 1/0", ready, pix_valid);
    end
  endtask

  task automatic test_clean_frame();
    pix_ready = 1'b1;
    drive_beat(24'($urandom), 1'b1, 1'b0, 1'b0);
    vectors++;
    if (pix_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL latency pix_valid=%0b, required 1", pix_valid);
    end
    send_pixels(1);
    drain();
  endtask

  task automatic test_hunt_drop();
    repeat (3) drive_beat(24'($urandom), 1'b0, 1'b0, 1'b0);
    vectors++;
    if (pix_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL hunt_drop pix_valid=%0b, required 0", pix_valid);
    end
    send_pixels(0);
    drain();
  endtask

  task automatic test_backpressure();
    pix_ready = 1'b0;
    send_pixels_two();
    vectors++;
    if (ready !== 1'b0 || pix_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_full ready=%0b pix_valid=%0b, required 0/1", ready, pix_valid);
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (xpixel !== 32'd0 || ypixel !== 32'd0 || colour_o !== exp_q[0].c) begin
      miscompares++;
      $display("FAIL bp_hold x=%0d y=%0d c=%h, required 0 0 %h", xpixel, ypixel, colour_o, exp_q[0].c);
    end
    pix_ready = 1'b1;
    send_pixels(2);
    drain();
  endtask

  task automatic send_pixels_two();
    drive_beat(24'($urandom), 1'b1, 1'b0, 1'b0);
    drive_beat(24'($urandom), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random_ready();
    rand_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      repeat ($urandom_range(0, 2)) drive_beat(24'($urandom), 1'b0, 1'b0, 1'b0);
      send_pixels(0);
    end
    rand_ready = 1'b0;
    drain();
  endtask

  task automatic test_lastx_err();
    drive_beat(24'($urandom), 1'b1, 1'b0, 1'b0);
    drive_beat(24'($urandom), 1'b0, 1'b0, 1'b0);
    drive_beat(24'($urandom), 1'b0, 1'b1, 1'b0);
    send_pixels(0);
    drain();
  endtask

  task automatic test_first_err();
    drive_beat(24'($urandom), 1'b1, 1'b0, 1'b0);
    drive_beat(24'($urandom), 1'b0, 1'b0, 1'b0);
    drive_beat(24'($urandom), 1'b1, 1'b0, 1'b0);
    send_pixels(1);
    drain();
  endtask

  task automatic test_mid_reset();
    pix_ready = 1'b0;
    send_pixels_two();
    #2 reset = 1'b1;
    model_reset();
    #1;
    vectors++;
    if (pix_valid !== 1'b0 || frame_count !== 16'd0 || err_geom !== 1'b0 || ready !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset pv=%0b fc=%0d err=%0b rdy=%0b, required 0 0 0 0",
               pix_valid, frame_count, err_geom, ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset_release ready=%0b, required 1", ready);
    end
    pix_ready = 1'b1;
    send_pixels(0);
    drain();
  endtask

  initial begin
    // Output scoreboard: every popped pixel must match the model in order.
    fork
      forever begin
        @(negedge clk);
        if (!reset && pix_valid && pix_ready) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL out_unexpected x=%0d y=%0d c=%h, required no pixel", xpixel, ypixel, colour_o);
          end else begin
            ce = exp_q.pop_front();
            if (xpixel !== 32'(ce.x) || ypixel !== 32'(ce.y) || colour_o !== ce.c) begin
              miscompares++;
              $display("FAIL out_pixel got (%0d,%0d) %h exp (%0d,%0d) %h",
                       xpixel, ypixel, colour_o, ce.x, ce.y, ce.c);
            end
          end
        end
      end
    join_none
    test_reset();
    test_clean_frame();
    test_hunt_drop();
    test_backpressure();
    test_random_ready();
    test_lastx_err();
    test_first_err();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule
